// File: rtl/perf_event_counter_bank.sv
// perf_event_counter_bank: per-channel event counters plus a free-running
// cycle counter. All counting freezes on core halt or on a watchdog timeout.
// The counters are read through a registered select port.
// Optional feature: define PERF_SATURATE_EN to make the counters saturate at
// all-ones. By default they wrap to zero. The overflow flag is set in both modes.
module perf_event_counter_bank #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned SEL_W   = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] evt,
  input  logic              hlt,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              timeout,
  output logic              frozen
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam logic [63:0] TO_CMP = 64'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  // Index NUM_CH holds the cycle counter. It is treated as a channel whose event is always set.
  logic [CNT_W-1:0] cnt_q [NUM_CH+1];
  logic [CNT_W-1:0] cnt_d [NUM_CH+1];
  logic [CNT_W:0]   nxt   [NUM_CH+1];
  logic [NUM_CH:0]  ovf_q, ovf_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [NUM_CH:0]  evt_ext;
  logic             act;
  logic             wd;

  // The +1 result of a counter. The top bit carries out of all-ones.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(1);
`ifdef PERF_SATURATE_EN
    if (s[CNT_W]) s[CNT_W-1:0] = '1;
`endif
    return s;
  endfunction

  assign evt_ext = {1'b1, evt};

  // Next-state: count when enabled and not halted, freeze on hlt or watchdog, clr overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    timeout_d = timeout_q;
    rd_d      = '0;
    wd        = 1'b0;
    act       = en && (state_q != S_HALTED);

    for (int unsigned i = 0; i <= NUM_CH; i++) begin
      nxt[i] = bump(cnt_q[i]);
    end

    if (act) begin
      // Counting is gated by en directly, so the cycle that enters COUNT also counts.
      for (int unsigned i = 0; i <= NUM_CH; i++) begin
        if (evt_ext[i]) begin
          cnt_d[i] = nxt[i][CNT_W-1:0];
          if (nxt[i][CNT_W]) ovf_d[i] = 1'b1;
        end
      end
      wd = (TIMEOUT != 0) && (64'(nxt[NUM_CH][CNT_W-1:0]) == TO_CMP);
      if (hlt || wd) state_d = S_HALTED;
      else           state_d = S_COUNT;
      if (wd) timeout_d = 1'b1;
    end else if (state_q != S_HALTED) begin
      state_d = S_IDLE;
    end

    if (clr) begin
      state_d   = S_IDLE;
      ovf_d     = '0;
      timeout_d = 1'b0;
      for (int unsigned i = 0; i <= NUM_CH; i++) begin
        cnt_d[i] = '0;
      end
    end

    // Read mux takes the post-update values, so rd_data has a 1-cycle latency.
    for (int unsigned i = 0; i <= NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) rd_d = cnt_d[i];
    end
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      rd_q      <= '0;
      for (int unsigned i = 0; i <= NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      rd_q      <= rd_d;
      for (int unsigned i = 0; i <= NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data = rd_q;
  assign ovf     = ovf_q;
  assign timeout = timeout_q;
  assign frozen  = (state_q == S_HALTED);

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Testbench for perf_event_counter_bank. Three configurations share one
// stimulus stream: the default build, an 8-bit build with no watchdog, and a
// 16-bit build with TIMEOUT=20. Each is compared every cycle against an
// arithmetic reference model.
module tb_perf_event_counter_bank;

`ifdef PERF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic [3:0] evt;
  logic       hlt;
  logic [2:0] rd_sel;

  logic [31:0] rd_m;
  logic [7:0]  rd_w;
  logic [15:0] rd_t;
  logic [4:0]  ovf_m, ovf_w, ovf_t;
  logic        to_m, to_w, to_t;
  logic        fr_m, fr_w, fr_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index 0 = main, 1 = wrap (8-bit), 2 = watchdog (TIMEOUT=20)
  int unsigned     cw   [3] = '{32, 8, 16};
  longint unsigned tov  [3] = '{64'd100000, 64'd0, 64'd20};
  longint unsigned m_cnt[3][5];
  logic [4:0]      m_ovf[3];
  bit              m_to [3];
  bit              m_hlt[3];
  longint unsigned m_rd [3];

  perf_event_counter_bank u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .hlt(hlt),
    .rd_sel(rd_sel), .rd_data(rd_m), .ovf(ovf_m), .timeout(to_m), .frozen(fr_m)
  );

  perf_event_counter_bank #(.CNT_W(8), .TIMEOUT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .hlt(hlt),
    .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w), .timeout(to_w), .frozen(fr_w)
  );

  perf_event_counter_bank #(.CNT_W(16), .TIMEOUT(20)) u_tmo (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .evt(evt), .hlt(hlt),
    .rd_sel(rd_sel), .rd_data(rd_t), .ovf(ovf_t), .timeout(to_t), .frozen(fr_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      longint unsigned mx;
      mx = (64'd1 << cw[k]) - 64'd1;
      if (!rst_n || clr) begin
        for (int c = 0; c < 5; c++) m_cnt[k][c] = 0;
        m_ovf[k] = '0;
        m_to[k]  = 1'b0;
        m_hlt[k] = 1'b0;
      end else if (en && !m_hlt[k]) begin
        for (int c = 0; c < 5; c++) begin
          if (c == 4 || evt[c]) begin
            if (m_cnt[k][c] == mx) begin
              m_ovf[k][c] = 1'b1;
              m_cnt[k][c] = SAT ? mx : 64'd0;
            end else begin
              m_cnt[k][c] = m_cnt[k][c] + 1;
            end
          end
        end
        if (tov[k] != 0 && m_cnt[k][4] == tov[k]) begin
          m_hlt[k] = 1'b1;
          m_to[k]  = 1'b1;
        end
        if (hlt) m_hlt[k] = 1'b1;
      end
      m_rd[k] = (rd_sel <= 3'd4) ? m_cnt[k][rd_sel] : 64'd0;
    end
  endtask

  task automatic compare_all();
    chk("main.rd",  64'(rd_m),  m_rd[0]);
    chk("main.ovf", 64'(ovf_m), 64'(m_ovf[0]));
    chk("main.to",  64'(to_m),  64'(m_to[0]));
    chk("main.fr",  64'(fr_m),  64'(m_hlt[0]));
    chk("wrap.rd",  64'(rd_w),  m_rd[1]);
    chk("wrap.ovf", 64'(ovf_w), 64'(m_ovf[1]));
    chk("wrap.to",  64'(to_w),  64'(m_to[1]));
    chk("wrap.fr",  64'(fr_w),  64'(m_hlt[1]));
    chk("tmo.rd",   64'(rd_t),  m_rd[2]);
    chk("tmo.ovf",  64'(ovf_t), 64'(m_ovf[2]));
    chk("tmo.to",   64'(to_t),  64'(m_to[2]));
    chk("tmo.fr",   64'(fr_t),  64'(m_hlt[2]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; evt = '0; hlt = 1'b0; rd_sel = 3'd4;
    tick();
    tick();
    chk("rst.rd",  64'(rd_m),  64'd0);
    chk("rst.ovf", 64'(ovf_m), 64'd0);
    chk("rst.to",  64'(to_m),  64'd0);
    chk("rst.fr",  64'(fr_m),  64'd0);
    rst_n = 1'b1;
    tick();

    // Ten enabled cycles with evt=0101
    en = 1'b1; evt = 4'b0101; rd_sel = 3'd4;
    for (int i = 0; i < 10; i++) tick();
    chk("basic.cyc", 64'(rd_m), 64'd10);
    chk("basic.fr",  64'(fr_m), 64'd0);
    en = 1'b0; evt = '0;
    rd_sel = 3'd0; tick(); chk("basic.ch0", 64'(rd_m), 64'd10);
    rd_sel = 3'd1; tick(); chk("basic.ch1", 64'(rd_m), 64'd0);
    rd_sel = 3'd2; tick(); chk("basic.ch2", 64'(rd_m), 64'd10);
    rd_sel = 3'd3; tick(); chk("basic.ch3", 64'(rd_m), 64'd0);

    // en low with an out-of-range select: counters hold and the read returns 0
    rd_sel = 3'd7; evt = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("oor.rd", 64'(rd_m), 64'd0);
    end
    en = 1'b1; evt = '0; rd_sel = 3'd4;
    tick();
    chk("resume.cyc", 64'(rd_m), 64'd11);
    tick();

    // Halt cycle still counts its own event, then everything freezes
    hlt = 1'b1; evt = 4'b0010; rd_sel = 3'd1;
    tick();
    chk("halt.fr",  64'(fr_m), 64'd1);
    chk("halt.ch1", 64'(rd_m), 64'd1);
    hlt = 1'b0; evt = 4'hF;
    for (int i = 0; i < 5; i++) tick();
    chk("halt.hold", 64'(rd_m), 64'd1);
    rd_sel = 3'd4; tick();
    chk("halt.cyc", 64'(rd_m), 64'd13);

    // clr wins over evt/hlt/en in the same cycle
    clr = 1'b1; hlt = 1'b1; evt = 4'hF; en = 1'b1;
    tick();
    chk("clr.rd",  64'(rd_m),  64'd0);
    chk("clr.ovf", 64'(ovf_m), 64'd0);
    chk("clr.fr",  64'(fr_m),  64'd0);
    chk("clr.to",  64'(to_m),  64'd0);
    clr = 1'b0; hlt = 1'b0; en = 1'b0; evt = '0;
    tick();

    // 256 increments of ch0: the 8-bit build overflows, and the watchdog build halts at 20
    en = 1'b1; evt = 4'b0001; rd_sel = 3'd0;
    for (int i = 0; i < 256; i++) tick();
    chk("ovf.ch0",  64'(rd_w),     SAT ? 64'hFF : 64'd0);
    chk("ovf.bit0", 64'(ovf_w[0]), 64'd1);
    en = 1'b0; evt = '0; rd_sel = 3'd4;
    tick();
    chk("wd.cyc", 64'(rd_t), 64'd20);
    chk("wd.to",  64'(to_t), 64'd1);
    chk("wd.fr",  64'(fr_t), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      clr    = ($urandom_range(0, 149) == 0);
      en     = ($urandom_range(0, 9) != 0);
      hlt    = ($urandom_range(0, 299) == 0);
      evt    = 4'($urandom);
      rd_sel = 3'($urandom_range(0, 7));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
